// File: rtl/mux_pkg.sv
// Shared constants, state encoding and select helpers for the mux serializer.
// No ports; imported by the stepper and the serializer top.
package mux_pkg;

  localparam int MUX_N = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
    return lsb_first ? 2'd0 : 2'd3;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
    return lsb_first ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain combinational 4-to-1 selector driven by the serializer.
// Ports: in[3:0] data, sel[1:0] select, out selected bit.
module mux4to1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/mux4to1_serializer_mux_sel_stepper.sv
// Select register: loads START, steps toward END, flags END.
// Ports: clk, rst_n (sync), load, step in; sel, is_end out.
module mux_sel_stepper
  import mux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             is_end
);

  localparam logic [SEL_W-1:0] START = sel_start(LSB_FIRST);
  localparam logic [SEL_W-1:0] END   = sel_end(LSB_FIRST);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  always_comb begin
    sel_d = sel_q;
    if (load) begin
      sel_d = START;
    end else if (step) begin
      sel_d = LSB_FIRST ? sel_q + 2'd1 : sel_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= START;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel    = sel_q;
  assign is_end = (sel_q == END);

endmodule

// File: rtl/mux4to1_serializer.sv
// Parallel-to-serial wrapper around an external mux4to1 with word counter.
// Ports: load valid/ready/data in, mux_in/mux_sel/mux_out to the mux,
// ser valid/ready/data/last out, busy and word_count status.
module mux4to1_serializer
  import mux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [MUX_N-1:0] load_data,
  output logic             load_ready,
  output logic [MUX_N-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  state_e           state_q;
  state_e           state_d;
  logic [MUX_N-1:0] mux_in_q;
  logic [MUX_N-1:0] mux_in_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             is_end;
  logic             beat;
  logic             last_beat;
  logic             accept;
  logic             step;

  always_comb begin
    busy      = (state_q == SHIFT);
    ser_valid = busy;
    ser_data  = mux_out;
    ser_last  = busy && is_end;
    beat      = ser_valid && ser_ready;
    last_beat = beat && ser_last;
    // Ready is a function of state and downstream only, never load_valid.
    load_ready = !busy || (ser_last && ser_ready);
    accept     = load_valid && load_ready;
    step       = beat && !ser_last;

    state_d = state_q;
    if (accept) begin
      state_d = SHIFT;
    end else if (last_beat) begin
      state_d = IDLE;
    end

    mux_in_d = accept ? load_data : mux_in_q;
    cnt_d    = cnt_q + CNT_W'(last_beat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mux_in_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mux_in_q <= mux_in_d;
      cnt_q    <= cnt_d;
    end
  end

  mux_sel_stepper #(
    .LSB_FIRST(LSB_FIRST)
  ) u_stepper (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (step),
    .sel   (mux_sel),
    .is_end(is_end)
  );

  assign mux_in     = mux_in_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_mux4to1_serializer.sv
// Bench for mux4to1_serializer: three variants wired to real mux4to1s,
// scoreboard of expected serial bits plus directed checks.
module tb_mux4to1_serializer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       ser_ready;

  logic [3:0] mi [3];
  logic [1:0] ms [3];
  logic       mo [3];
  logic       lr [3];
  logic       sv [3];
  logic       sd [3];
  logic       sl [3];
  logic       bz [3];
  logic [7:0] wc0;
  logic [7:0] wc1;
  logic [1:0] wc2;

  int checks = 0;
  int errors = 0;

  logic [1:0] sb [3][$];
  int         mcnt [3];
  logic [1:0] ent;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  mux4to1_serializer #(.LSB_FIRST(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr[0]), .mux_in(mi[0]),
    .mux_sel(ms[0]), .mux_out(mo[0]), .ser_valid(sv[0]),
    .ser_data(sd[0]), .ser_last(sl[0]), .ser_ready(ser_ready),
    .busy(bz[0]), .word_count(wc0)
  );
  mux4to1_serializer #(.LSB_FIRST(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr[1]), .mux_in(mi[1]),
    .mux_sel(ms[1]), .mux_out(mo[1]), .ser_valid(sv[1]),
    .ser_data(sd[1]), .ser_last(sl[1]), .ser_ready(ser_ready),
    .busy(bz[1]), .word_count(wc1)
  );
  mux4to1_serializer #(.LSB_FIRST(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr[2]), .mux_in(mi[2]),
    .mux_sel(ms[2]), .mux_out(mo[2]), .ser_valid(sv[2]),
    .ser_data(sd[2]), .ser_last(sl[2]), .ser_ready(ser_ready),
    .busy(bz[2]), .word_count(wc2)
  );

  mux4to1 u_mux0 (.in(mi[0]), .sel(ms[0]), .out(mo[0]));
  mux4to1 u_mux1 (.in(mi[1]), .sel(ms[1]), .out(mo[1]));
  mux4to1 u_mux2 (.in(mi[2]), .sel(ms[2]), .out(mo[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        sb[k].delete();
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sv[k] && ser_ready) begin
          if (sb[k].size() == 0) begin
            chk("spurious_bit", 1, 0);
          end else begin
            ent = sb[k].pop_front();
            chk("ser_data", int'(sd[k]), int'(ent[0]));
            chk("ser_last", int'(sl[k]), int'(ent[1]));
            if (ent[1]) mcnt[k]++;
          end
        end
        if (lr[k] && load_valid) begin
          for (int b = 0; b < 4; b++) begin
            sb[k].push_back({b == 3, load_data[(k == 1) ? 3 - b : b]});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w);
    load_valid = 1'b1;
    load_data  = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((bz[0] || bz[1] || bz[2]) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(n < max), 1);
  endtask

  initial begin
    int n_acc;
    int guard;
    int busy_cnt;
    int lr_cnt;
    logic acc;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;
    ser_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_valid", int'(sv[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_ready", int'(lr[0]), 1);
    chk("rst_sel", int'(ms[0]), 0);
    chk("rst_sel_msb", int'(ms[1]), 3);
    chk("rst_in", int'(mi[0]), 0);
    chk("rst_cnt", int'(wc0), 0);
    step();

    ser_ready = 1'b1;
    send(4'b1011);
    chk("first_latency", int'(sv[0]), 1);
    drain(20);
    chk("basic_cnt", int'(wc0), 1);
    chk("basic_idle", int'(bz[0]), 0);

    send(4'b0110);
    step();
    ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_sel", int'(ms[0]), 1);
      chk("bp_data", int'(sd[0]), 1);
      chk("bp_last", int'(sl[0]), 0);
      step();
    end
    ser_ready = 1'b1;
    drain(20);
    chk("bp_cnt", int'(wc0), 2);

    load_valid = 1'b1;
    load_data  = 4'hA;
    n_acc = 0;
    guard = 0;
    busy_cnt = 0;
    lr_cnt = 0;
    while (!(n_acc == 2 && !bz[0]) && guard < 30) begin
      @(negedge clk);
      if (bz[0]) begin
        busy_cnt++;
        if (lr[0]) lr_cnt++;
      end
      acc = lr[0] && load_valid;
      step();
      guard++;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) load_data = 4'h5;
        else load_valid = 1'b0;
      end
    end
    load_valid = 1'b0;
    chk("b2b_timeout", int'(guard < 30), 1);
    chk("b2b_busy_cycles", busy_cnt, 8);
    chk("b2b_ready_pulses", lr_cnt, 2);
    chk("b2b_cnt", int'(wc0), 4);

    send(4'b1000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("msb_data", int'(sd[1]), (i == 0) ? 1 : 0);
      chk("msb_sel", int'(ms[1]), 3 - i);
      step();
    end
    drain(20);
    chk("msb_cnt", int'(wc1), 5);
    chk("cnt_5", int'(wc0), 5);
    chk("cnt_wrap", int'(wc2), 1);
    chk("cnt_model", int'(wc0), mcnt[0]);
    chk("cnt_wrap_model", int'(wc2), mcnt[2] % 4);

    send(4'hF);
    step();
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_valid", int'(sv[0]), 0);
    chk("mid_rst_in", int'(mi[0]), 0);
    chk("mid_rst_cnt", int'(wc0), 0);
    chk("mid_rst_sel_msb", int'(ms[1]), 3);
    rst_n = 1'b1;
    step();

    send(4'h9);
    drain(20);
    chk("post_rst_cnt", int'(wc0), 1);
    for (int k = 0; k < 3; k++) begin
      chk("sb_empty", sb[k].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4to1_serializer.md
Name: mux4to1_serializer

Overview:
- Feed-and-drain stage for the 4-to-1 mux (`mux4to1`: in[3:0], sel[1:0] -> out).
- Accepts a 4-bit word on a valid/ready load port and drives the word onto the mux `in` through a register.
- Steps the mux `sel` one position per accepted output beat and returns the mux `out` bit as a serial stream on a valid/ready port.
- Turns the combinational selector into a parallel-to-serial converter, with a completed-word counter for bring-up.

Parameters:
- LSB_FIRST, 1: 1 = sel steps 0->3; 0 = sel steps 3->0.
- CNT_W, 8: width of the completed-word counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  4  word to serialize.
- load_ready  out  1  block can accept a word this cycle.
- mux_in  out  4  registered word, connects to mux4to1 in.
- mux_sel  out  2  registered select, connects to mux4to1 sel.
- mux_out  in  1  mux4to1 out (combinational from mux_in/mux_sel).
- ser_valid  out  1  ser_data holds a valid bit.
- ser_data  out  1  current serial bit (= mux_out).
- ser_last  out  1  current bit is the 4th bit of the word.
- ser_ready  in  1  downstream accepts the bit.
- busy  out  1  word in flight (state SHIFT).
- word_count  out  CNT_W  number of words fully drained.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - mux_in=0, mux_sel=START, word_count=0, ser_valid=0, busy=0.
  - START = 0 if LSB_FIRST else 3; END = 3 if LSB_FIRST else 0.
  - Reset mid-word drops the word with no partial output. Reset dominates every other event in the same cycle.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0, ser_last=0.
  - On load_valid: mux_in<=load_data, mux_sel<=START, state<=SHIFT.
  - Latency: the first bit is valid on the cycle after acceptance.
- SHIFT:
  - ser_valid=1, busy=1, ser_data=mux_out, ser_last=(mux_sel==END).
- Handshake: a beat transfers when ser_valid && ser_ready.
  - ser_ready=0: mux_sel, mux_in, ser_data and ser_last all hold stable. No bit is dropped or repeated.
  - Beat with ser_last=0: mux_sel steps +1 (LSB_FIRST) or -1 (otherwise).
  - Beat with ser_last=1: word_count increments, wrapping from all-ones to 0.
    - If load_valid=1 in the same cycle: back-to-back reload (mux_in<=load_data, mux_sel<=START, stay SHIFT, no bubble).
    - Otherwise: state<=IDLE.
- load_ready in SHIFT = ser_last && ser_ready. It is combinational and must not depend on load_valid.
- load_valid while SHIFT and not on the last beat: not accepted. The upstream must hold its word.
- ser_valid must not depend combinationally on ser_ready.
- mux_in changes only on load acceptance. mux_sel changes only on acceptance or a beat.
- Throughput: 4 cycles per word when ser_ready=1 continuously and load_valid=1 continuously.
- The mux is external and not instantiated. ser_data is passed through from mux_out with zero cycles added.

Decomposition:
- Shared package mux_pkg:
  - constants MUX_N=4, SEL_W=2.
  - state enum {IDLE, SHIFT}.
  - START/END select helper constants.
- One natural sub-module: mux_sel_stepper. It holds the 2-bit select register with load-to-START, step up/down, and an is_END flag.
- Top: FSM, data register and word counter.
- Bench wires mux4to1_serializer to the real mux4to1.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> ser_valid=0, busy=0, load_ready=1, mux_sel=0, mux_in=0, word_count=0.
- Basic LSB_FIRST: load 4'b1011, ser_ready=1 -> cycles 1..4 after acceptance give ser_data=1,1,0,1. ser_last only on cycle 4. word_count=1. Return to IDLE.
- Backpressure: load 4'b0110, drop ser_ready for 3 cycles during the 2nd bit -> ser_data stays 1 and mux_sel stays 1 throughout. Final stream is 0,1,1,0 with no repeats.
- Back-to-back: load_valid held high with words 4'hA then 4'h5 -> 8 consecutive valid bits 0,1,0,1,1,0,1,0. load_ready pulses only on the last beats. word_count=2.
- LSB_FIRST=0: load 4'b1000 -> stream is 1,0,0,0 and mux_sel goes 3,2,1,0.
- Mid-word reset and counter wrap:
  - rst_n low after bit 2 of 4'hF -> next cycle ser_valid=0, mux_in=0, word_count=0.
  - With CNT_W=2, five words -> word_count=1.
